// File: rtl/muldiv_if.sv
// ----------------------------------------------------------------------------
// muldiv_if : request/response bundle between the issue stage and muldiv_unit.
//
// Signals
//   start       request, sampled by the unit only while it is idle
//   funct3      RV32M operation select
//   rs1_data    operand A (dividend / multiplicand)
//   rs2_data    operand B (divisor / multiplier)
//   rd_addr     destination register index
//   flush       synchronous abort from the pipeline
//   busy        unit is not idle; the core stalls on it
//   done        one-cycle pulse, result valid
//   result      operation result, held until the next accepted start
//   rd_addr_out destination index latched at start
//   we_out      register-file write enable (never set for x0)
//
// Modports
//   master : issue side, drives the request and flush
//   slave  : the execution unit
// ----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [2:0]        funct3;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic [4:0]        rd_addr;
  logic              flush;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic [4:0]        rd_addr_out;
  logic              we_out;

  modport master (
    output start, funct3, rs1_data, rs2_data, rd_addr, flush,
    input  busy, done, result, rd_addr_out, we_out
  );

  modport slave (
    input  start, funct3, rs1_data, rs2_data, rd_addr, flush,
    output busy, done, result, rd_addr_out, we_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply / divide execution unit.
//
// Sits behind the register-file read ports; its result, destination index
// and write enable go back to the register-file write port via writeback.
// Multiply is radix-2 shift-add, divide is restoring division, both on
// operand magnitudes with sign correction applied in a final FIX cycle.
// Division by zero and signed overflow are resolved at the start edge.
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    muldiv_if.slave (start/funct3/rs1_data/rs2_data/rd_addr/flush in,
//          busy/done/result/rd_addr_out/we_out out, all outputs registered)
//
// Configuration
//   MULDIV_FAST_MUL_EN  when defined, the four multiply ops bypass the
//                       iterative loop and use one combinational multiplier
//                       on the latched magnitudes (done two cycles after
//                       start). Divides are unaffected. When undefined no
//                       hardware multiplier is built.
//
// DATA_W must be 32: the step counter is 5 bits wide.
// ----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_W = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  muldiv_if.slave bus
);

  localparam int                PW        = 2 * DATA_W;
  localparam logic [DATA_W-1:0] ZERO      = {DATA_W{1'b0}};
  localparam logic [DATA_W-1:0] ALL_ONES  = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [4:0]        LAST_STEP = 5'd31;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Architectural / datapath state
  state_t            state_r;
  logic [4:0]        cnt_r;
  logic [PW-1:0]     acc_r;     // mul: {partial high, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0] a_mag_r;
  logic [DATA_W-1:0] b_mag_r;
  logic              a_neg_r;
  logic              b_neg_r;
  logic [2:0]        f3_r;
  logic [4:0]        rd_r;
  logic [DATA_W-1:0] result_r;
  logic              busy_r;
  logic              done_r;
  logic              we_r;

  // Start-edge decode
  logic              a_signed_s;
  logic              b_signed_s;
  logic              rs1_neg_s;
  logic              rs2_neg_s;
  logic [DATA_W-1:0] rs1_mag_s;
  logic [DATA_W-1:0] rs2_mag_s;
  logic              is_div_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic              special_s;
  logic [DATA_W-1:0] special_res_s;

  // Iteration step
  logic [DATA_W:0]   mul_sum_s;
  logic [DATA_W:0]   div_shift_s;
  logic [DATA_W:0]   div_trial_s;
  logic [PW-1:0]     step_s;

  // Sign fix-up and output select
  logic [PW-1:0]     mul_mag_s;
  logic [PW-1:0]     prod_s;
  logic [DATA_W-1:0] quo_s;
  logic [DATA_W-1:0] rem_s;
  logic [DATA_W-1:0] fix_res_s;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
  // Single-cycle unsigned product of the latched magnitudes
  assign mul_mag_s = {{DATA_W{1'b0}}, a_mag_r} * {{DATA_W{1'b0}}, b_mag_r};
`else
  localparam bit FAST_MUL = 1'b0;
  // Product magnitude is whatever the shift-add loop accumulated
  assign mul_mag_s = acc_r;
`endif

  // Which operands are interpreted as two's complement for this funct3.
  // MUL returns the low word, which is sign-independent, so it runs unsigned.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (bus.funct3)
      F3_MULH, F3_DIV, F3_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      F3_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
  end

  // Operand sign flags and magnitudes (0x80000000 maps to itself, which is
  // the correct unsigned magnitude)
  always_comb begin
    rs1_neg_s = a_signed_s & bus.rs1_data[DATA_W-1];
    rs2_neg_s = b_signed_s & bus.rs2_data[DATA_W-1];
    if (rs1_neg_s) begin
      rs1_mag_s = ZERO - bus.rs1_data;
    end else begin
      rs1_mag_s = bus.rs1_data;
    end
    if (rs2_neg_s) begin
      rs2_mag_s = ZERO - bus.rs2_data;
    end else begin
      rs2_mag_s = bus.rs2_data;
    end
  end

  // Divide special cases that bypass the loop and finish in one cycle
  always_comb begin
    is_div_s   = bus.funct3[2];
    div_zero_s = is_div_s && (bus.rs2_data == ZERO);
    div_ovf_s  = is_div_s && !bus.funct3[0] &&
                 (bus.rs1_data == MIN_NEG) && (bus.rs2_data == ALL_ONES);
    special_s  = div_zero_s | div_ovf_s;
    if (div_zero_s) begin
      if (bus.funct3[1]) begin
        special_res_s = bus.rs1_data;
      end else begin
        special_res_s = ALL_ONES;
      end
    end else if (div_ovf_s) begin
      if (bus.funct3[1]) begin
        special_res_s = ZERO;
      end else begin
        special_res_s = MIN_NEG;
      end
    end else begin
      special_res_s = ZERO;
    end
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    // Multiply: add multiplicand to the high half when the current
    // multiplier LSB is set, then shift the 65-bit result right by one.
    mul_sum_s = {1'b0, acc_r[PW-1:DATA_W]} +
                (acc_r[0] ? {1'b0, a_mag_r} : {(DATA_W+1){1'b0}});
    // Divide: shift {remainder, quotient} left, trial-subtract the divisor.
    // Bit DATA_W of the trial is set exactly when the subtraction underflows.
    div_shift_s = {acc_r[PW-1:DATA_W], acc_r[DATA_W-1]};
    div_trial_s = div_shift_s - {1'b0, b_mag_r};
    if (f3_r[2]) begin
      if (div_trial_s[DATA_W]) begin
        step_s = {div_shift_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b0};
      end else begin
        step_s = {div_trial_s[DATA_W-1:0], acc_r[DATA_W-2:0], 1'b1};
      end
    end else begin
      step_s = {mul_sum_s, acc_r[DATA_W-1:1]};
    end
  end

  // Sign correction and final result select
  always_comb begin
    if (a_neg_r ^ b_neg_r) begin
      prod_s = {PW{1'b0}} - mul_mag_s;
      quo_s  = ZERO - acc_r[DATA_W-1:0];
    end else begin
      prod_s = mul_mag_s;
      quo_s  = acc_r[DATA_W-1:0];
    end
    // Remainder follows the dividend's sign
    if (a_neg_r) begin
      rem_s = ZERO - acc_r[PW-1:DATA_W];
    end else begin
      rem_s = acc_r[PW-1:DATA_W];
    end
    case (f3_r)
      F3_MUL:                       fix_res_s = prod_s[DATA_W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_res_s = prod_s[PW-1:DATA_W];
      F3_DIV, F3_DIVU:              fix_res_s = quo_s;
      F3_REM, F3_REMU:              fix_res_s = rem_s;
      default:                      fix_res_s = ZERO;
    endcase
  end

  // Control FSM with operand latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      acc_r    <= {PW{1'b0}};
      a_mag_r  <= ZERO;
      b_mag_r  <= ZERO;
      a_neg_r  <= 1'b0;
      b_neg_r  <= 1'b0;
      f3_r     <= 3'b000;
      rd_r     <= 5'd0;
      result_r <= ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      we_r     <= 1'b0;
    end else if (bus.flush) begin
      // Abort wins over everything, including a coincident start
      state_r <= ST_IDLE;
      cnt_r   <= 5'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      we_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          we_r   <= 1'b0;
          if (bus.start) begin
            a_mag_r <= rs1_mag_s;
            b_mag_r <= rs2_mag_s;
            a_neg_r <= rs1_neg_s;
            b_neg_r <= rs2_neg_s;
            f3_r    <= bus.funct3;
            rd_r    <= bus.rd_addr;
            cnt_r   <= 5'd0;
            busy_r  <= 1'b1;
            // Low half seeds the multiplier (mul) or the dividend (div);
            // the high half starts empty.
            acc_r   <= {ZERO, (is_div_s ? rs1_mag_s : rs2_mag_s)};
            if (special_s) begin
              result_r <= special_res_s;
              state_r  <= ST_DONE;
              done_r   <= 1'b1;
              we_r     <= (bus.rd_addr != 5'd0);
            end else if (FAST_MUL && !is_div_s) begin
              state_r <= ST_FIX;
            end else begin
              state_r <= ST_CALC;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_CALC: begin
          acc_r <= step_s;
          cnt_r <= cnt_r + 5'd1;   // wraps back to 0 after the 32nd step
          if (cnt_r == LAST_STEP) begin
            state_r <= ST_FIX;
          end else begin
            state_r <= ST_CALC;
          end
        end
        ST_FIX: begin
          result_r <= fix_res_s;
          state_r  <= ST_DONE;
          done_r   <= 1'b1;
          we_r     <= (rd_r != 5'd0);
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          we_r    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 5'd0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.result      = result_r;
  assign bus.rd_addr_out = rd_r;
  assign bus.we_out      = we_r;

endmodule
